div_iter: RTL and testbench



---
 rtl/div_iter_pkg.sv | 14 +
 rtl/div_iter_if.sv | 26 ++
 rtl/div_iter.sv | 158 +++++++++++++++
 tb/tb_div_iter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
// The optional DIV_EARLY_OUT_EN macro is consumed by div_iter.sv.
package div_iter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle between execute (master) and the divider (slave).
interface div_iter_if
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic                  div_start_i;
  logic                  div_signed_i;
  logic [DATA_W-1:0]     div_data1_i;
  logic [DATA_W-1:0]     div_data2_i;
  logic                  div_cancel_i;
  logic [2*DATA_W-1:0]   div_result_o;
  logic                  div_done_o;

  modport master (
    output div_start_i, div_signed_i, div_data1_i, div_data2_i, div_cancel_i,
    input  div_result_o, div_done_o
  );

  modport slave (
    input  div_start_i, div_signed_i, div_data1_i, div_data2_i, div_cancel_i,
    output div_result_o, div_done_o
  );

endinterface

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and |a|<|b| in one cycle.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  div_bus
);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  quo_sign_q, quo_sign_d;
  logic                  rem_sign_q, rem_sign_d;
  logic                  div_zero_q, div_zero_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic [DATA_W:0]       rem_q, rem_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  done_q, done_d;

  logic [DATA_W:0]       shift_rem;
  logic [DATA_W:0]       trial;
  logic [DATA_W-1:0]     abs_dividend;
  logic [DATA_W-1:0]     abs_divisor;
  logic                  in_quo_sign;
  logic                  in_rem_sign;

  // 0x80000000 maps to itself, which read as unsigned is the required 2^31.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] fix_up(input logic [DATA_W-1:0] quo,
                                                 input logic [DATA_W-1:0] rem,
                                                 input logic quo_neg,
                                                 input logic rem_neg);
    logic [DATA_W-1:0] q_out;
    logic [DATA_W-1:0] r_out;
    q_out = quo_neg ? -quo : quo;
    r_out = rem_neg ? -rem : rem;
    return {r_out, q_out};
  endfunction

  assign shift_rem    = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
  assign trial        = shift_rem - {1'b0, divisor_q};
  assign abs_dividend = abs_val(div_bus.div_data1_i, div_bus.div_signed_i);
  assign abs_divisor  = abs_val(div_bus.div_data2_i, div_bus.div_signed_i);
  assign in_quo_sign  = div_bus.div_signed_i &
                        (div_bus.div_data1_i[DATA_W-1] ^ div_bus.div_data2_i[DATA_W-1]);
  assign in_rem_sign  = div_bus.div_signed_i & div_bus.div_data1_i[DATA_W-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_sign_d = quo_sign_q;
    rem_sign_d = rem_sign_q;
    div_zero_d = div_zero_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    result_d   = result_q;
    done_d     = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (div_bus.div_start_i && !div_bus.div_cancel_i) begin
          quo_sign_d = in_quo_sign;
          rem_sign_d = in_rem_sign;
          div_zero_d = (div_bus.div_data2_i == '0);
          divisor_d  = abs_divisor;
          quo_d      = abs_dividend;
          rem_d      = '0;
          cnt_d      = CNT_W'(DATA_W);
          state_d    = DIV_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (div_bus.div_data2_i == '0) begin
            state_d  = DIV_DONE;
            done_d   = 1'b1;
            result_d = fix_up('1, abs_dividend, 1'b0, in_rem_sign);
          end else if (abs_dividend < abs_divisor) begin
            state_d  = DIV_DONE;
            done_d   = 1'b1;
            result_d = fix_up('0, abs_dividend, in_quo_sign, in_rem_sign);
          end
`endif
        end
      end

      DIV_CALC: begin
        if (!trial[DATA_W]) begin
          rem_d = trial;
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = shift_rem;
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        // Result and done are registered on the final iteration so they appear together in DONE.
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DIV_DONE;
          done_d   = 1'b1;
          result_d = fix_up(quo_d, rem_d[DATA_W-1:0],
                            quo_sign_q & ~div_zero_q, rem_sign_q);
        end
      end

      DIV_DONE: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    if (div_bus.div_cancel_i) begin
      state_d  = DIV_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      quo_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      div_zero_q <= 1'b0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_sign_q <= quo_sign_d;
      rem_sign_q <= rem_sign_d;
      div_zero_q <= div_zero_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign div_bus.div_result_o = result_q;
  assign div_bus.div_done_o   = done_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: vector table, random ops, cancel and reset sequences.
module tb_div_iter;

  localparam int LAT_FULL = 33;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;
  logic [63:0] sb_q[$];

  div_iter_if #(.DATA_W(32)) bus ();

  div_iter dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Independent reference using 64-bit signed arithmetic (truncating division).
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_latency(input logic sgn, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || mag(a, sgn) < mag(b, sgn)) return 1;
`endif
    return LAT_FULL;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one op with start held until done, then checks latency, result and single-cycle done.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp);
    int cycles;
    int lat;
    logic [63:0] want;
    lat = exp_latency(sgn, a, b);
    sb_q.push_back(exp);
    bus.div_start_i  = 1'b1;
    bus.div_signed_i = sgn;
    bus.div_data1_i  = a;
    bus.div_data2_i  = b;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.div_done_o && cycles < 60);
    bus.div_start_i = 1'b0;
    checkOutput("latency", 64'(cycles), 64'(lat));
    want = sb_q.pop_front();
    if (bus.div_done_o) checkOutput("result", bus.div_result_o, want);
    else checkOutput("done_timeout", 64'(bus.div_done_o), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", 64'(bus.div_done_o), 64'd0);
  endtask

  task automatic count_done(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.div_done_o) hits++;
    end
  endtask

  vec_t vecs[12];

  initial begin
    int hits;
    logic [31:0] ra, rb;
    logic rs;

    assert_count = 0;
    fail_count   = 0;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2]  = '{1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  {32'h0000_0000, 32'hFFFF_FFFF}};
    vecs[5]  = '{1'b1, 32'h0000_0005,  32'h0000_0000,  {32'h0000_0005, 32'hFFFF_FFFF}};
    vecs[6]  = '{1'b0, 32'h8000_0000,  32'h0000_0000,  {32'h8000_0000, 32'hFFFF_FFFF}};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFB,  32'h0000_0000,  {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
    vecs[8]  = '{1'b0, 32'h0000_0003,  32'h0000_000A,  {32'h0000_0003, 32'h0000_0000}};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFD,  32'h0000_000A,  {32'hFFFF_FFFD, 32'h0000_0000}};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h0000_0001}};
    vecs[11] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'h0000_000E}};

    bus.div_start_i  = 1'b0;
    bus.div_signed_i = 1'b0;
    bus.div_data1_i  = '0;
    bus.div_data2_i  = '0;
    bus.div_cancel_i = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_done", 64'(bus.div_done_o), 64'd0);
    checkOutput("reset_result", bus.div_result_o, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table ops run back-to-back: each start is re-raised the cycle after done.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    for (int i = 0; i < 8; i++) begin
      rs = (i % 2) == 0;
      ra = $urandom;
      rb = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 7) rb = 32'hFFFF_FFF0;
      applyStimulus(rs, ra, rb, model(rs, ra, rb));
    end

    // Cancel at iteration 10, then an unsigned 9/3 one idle cycle later.
    bus.div_start_i  = 1'b1;
    bus.div_signed_i = 1'b0;
    bus.div_data1_i  = 32'd100;
    bus.div_data2_i  = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    bus.div_start_i  = 1'b0;
    bus.div_cancel_i = 1'b1;
    @(posedge clk);
    #1;
    bus.div_cancel_i = 1'b0;
    checkOutput("cancel_no_done", 64'(bus.div_done_o), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Synchronous reset mid-CALC clears outputs and leaves the FSM idle.
    bus.div_start_i  = 1'b1;
    bus.div_signed_i = 1'b0;
    bus.div_data1_i  = 32'd1000;
    bus.div_data2_i  = 32'd3;
    repeat (6) @(posedge clk);
    #1;
    bus.div_start_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("midcalc_reset_done", 64'(bus.div_done_o), 64'd0);
    checkOutput("midcalc_reset_result", bus.div_result_o, 64'd0);
    count_done(40, hits);
    checkOutput("idle_after_reset", 64'(hits), 64'd0);

    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, model(1'b1, 32'hFFFF_FF9C, 32'd7));
    applyStimulus(1'b0, 32'd81, 32'd9, {32'd0, 32'd9});

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
